uart_rx_monitor: RTL and testbench
==================================

# uart_rx_monitor

Synthesizable UART receiver with a receive FIFO that consumes the SoC's UART0 serial TX line (`RsTx_Sys0_SS0_S0`) on the FPGA validation build. It decodes 8N1 frames into bytes and buffers them. A downstream consumer (debug bridge, LED/console logic) drains them over a valid/ready stream. Sticky error flags capture framing errors and overflow.

## Interface
- `CLKS_PER_BIT`, 16 — HCLK cycles per UART bit. The default matches 12 MHz HCLK at 750 kbaud. Must be ≥ 4 and even.
- `FIFO_DEPTH`, 16 — receive FIFO entries. Must be a power of two, ≥ 2.
- `HCLK` in 1 — system clock; all logic is on its rising edge.
- `HRESETn` in 1 — asynchronous active-low reset.
- `rx_i` in 1 — serial input, idle high, asynchronous to HCLK.
- `m_data` out 8 — byte at the FIFO head (first-word fall-through).
- `m_valid` out 1 — FIFO not empty.
- `m_ready` in 1 — consumer accepts the head byte when `m_valid & m_ready`.
- `level` out $clog2(FIFO_DEPTH)+1 — current FIFO occupancy.
- `busy` out 1 — receiver is not in IDLE.
- `frame_err` out 1 — sticky; set when a stop bit is sampled low.
- `overflow` out 1 — sticky; set when a byte completes while the FIFO is full with no pop that cycle.
- `clr_err` in 1 — synchronous clear of all sticky flags.

## Operation
- `rx_i` passes through a 2-flop synchronizer, both flops reset to 1. `rx_s` is the second flop.
- Bit counter: tick counter width is $clog2(CLKS_PER_BIT); bit index is 0..7. All counters reset to 0.
- States:
  - IDLE → START on `rx_s==0`.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If `rx_s==1`, it is a false start: return to IDLE with no push. Otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into the shift register. Then go to STOP (or PARITY when configured).
  - STOP: sample after CLKS_PER_BIT cycles.
    - `rx_s==1`: push the byte and go to IDLE.
    - `rx_s==0`: set `frame_err`, no push, go to BREAK.
  - BREAK: stay until `rx_s==1`, then go to IDLE. A continuous low line therefore yields exactly one frame error, not repeated frames.
- FIFO rules:
  - Push while full with no pop: the byte is dropped, FIFO contents are unchanged, and `overflow` is set.
  - Push while full with a pop in the same cycle: the push is accepted and `level` stays at FIFO_DEPTH.
  - Pop while empty is ignored.
  - Push and pop in the same cycle at any other level: `level` is unchanged.
- `m_data` holds its value while `m_valid & ~m_ready`.
- `clr_err` asserted in the same cycle as a set event: the set wins.
- Reset mid-frame: the state returns to IDLE immediately, the partial byte is discarded, and the FIFO is emptied.

## Timing
- Reset values:
  - `m_valid`=0, `m_data`=0, `level`=0
  - `busy`=0, `frame_err`=0, `overflow`=0
  - state IDLE, synchronizer flops 1
- Start detection: `busy` rises 3 HCLK edges after `rx_i` falls, counting the 2 synchronizer stages plus the state register.
- Byte latency: `m_valid` rises exactly 3 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles after the `rx_i` falling edge. That is 156 cycles at the default, with an empty FIFO.
- Back-to-back frames: the receiver returns to IDLE mid-stop-bit. A new start edge arriving immediately after the stop-bit period is detected.
- Pop: `level` decrements and the next head appears on `m_data` on the edge that samples `m_valid & m_ready`.
- Sticky flags update on the same edge as the triggering sample.

## Configuration
- `UART_RX_MONITOR_PARITY_EN` defined:
  - Adds state PARITY between DATA and STOP, sampled CLKS_PER_BIT after the last data bit. Parity is even.
  - Adds output port `parity_err` (1 bit, sticky, reset 0, cleared by `clr_err`).
  - A byte with bad parity is still pushed if its stop bit is good.
  - Byte latency increases by CLKS_PER_BIT.
- Undefined: the frame is 8N1 and the `parity_err` port does not exist.

## Structure
- Package `uart_rx_monitor_pkg`:
  - state enum (`IDLE, START, DATA, PARITY, STOP, BREAK`)
  - `UART_DATA_W`=8
  - localparam helper for the tick-counter width
- Sub-module `uart_rx_fifo`: synchronous first-word-fall-through FIFO.
  - Parameters: DEPTH, WIDTH.
  - Ports: push, push_data, pop, head data, empty, full, level.
  - The overflow decision stays in the top level.

## Test plan
- Single frame: drive 0x41 at CLKS_PER_BIT=16 → `m_valid` rises 156 cycles after the start edge, `m_data`=0x41, `level`=1; assert `m_ready` → `level`=0, `m_valid`=0.
- Burst with no backpressure: send 0x00, 0xFF, 0x55, 0xA5 back-to-back → FIFO pops return them in order; `frame_err`=0.
- False start: pull `rx_i` low for 4 cycles → `busy` pulses and then returns low, no push, `level`=0.
- Framing error / break: hold `rx_i` low for 40 bit times → `frame_err`=1, exactly zero pushes; after the line returns high, 0x3C is received correctly; `clr_err` → `frame_err`=0.
- Overflow: with `m_ready`=0, send 17 bytes 0x01..0x11 → `level`=16, `overflow`=1, pops yield 0x01..0x10. Then repeat with a pop in the same cycle as the 17th push → `overflow` stays 0.
- Reset mid-frame: deassert HRESETn during data bit 4 → all outputs return to reset values; the next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_monitor_pkg.sv
// Shared types and constants for the UART receive monitor.
package uart_rx_monitor_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    // Width of the per-bit tick counter; never narrower than one bit.
    function automatic int tick_w(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_monitor_if.sv
// Byte stream from the receiver FIFO head to a downstream consumer.
// master drives data/valid, slave drives ready.
interface uart_rx_monitor_if;

    logic [uart_rx_monitor_pkg::UART_DATA_W-1:0] m_data;
    logic                                        m_valid;
    logic                                        m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/uart_rx_monitor_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is only
// accepted when a pop frees the head slot on the same edge; the caller
// decides whether a rejected push is an error.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = mem_q[rd_q];
    assign level_o = level_q;

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART 8N1 receiver feeding a FWFT byte FIFO, with sticky framing and
// overflow flags. Define UART_RX_MONITOR_PARITY_EN to add an even parity
// bit between data and stop, and the sticky parity_err output.
module uart_rx_monitor
    import uart_rx_monitor_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          rx_i,
    uart_rx_monitor_if.master             stream,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overflow,
`ifdef UART_RX_MONITOR_PARITY_EN
    output logic                          parity_err,
`endif
    input  logic                          clr_err
);

    localparam int                TICK_W  = tick_w(CLKS_PER_BIT);
    localparam logic [TICK_W-1:0] HALF_M1 = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_M1 = TICK_W'(CLKS_PER_BIT - 1);

    rx_state_e              state_q;
    logic [TICK_W-1:0]      tick_q;
    logic [2:0]             bit_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic                   busy_q;
    logic                   push_q;
    logic                   sync1_q;
    logic                   rx_s_q;
    logic                   frame_err_q;
    logic                   overflow_q;
    logic                   tick_full;
    logic                   frame_set;
    logic                   ovf_set;
    logic                   fifo_empty;
    logic                   fifo_full;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            rx_s_q  <= sync1_q;
        end
    end

    assign tick_full = (tick_q == FULL_M1);
    assign frame_set = (state_q == STOP) && tick_full && !rx_s_q;
    // A completed byte is lost only if the head is not leaving on the same edge.
    assign ovf_set   = push_q & fifo_full & ~stream.m_ready;

    // Receive FSM: start-bit qualify at mid-bit, then sample each bit centre.
    // The push is registered, so the byte lands in the FIFO one edge after the stop sample.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            push_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                        tick_q  <= '0;
                    end
                end
                START: begin
                    if (tick_q == HALF_M1) begin
                        tick_q <= '0;
                        bit_q  <= '0;
                        if (rx_s_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_full) begin
                        tick_q  <= '0;
                        shift_q <= {rx_s_q, shift_q[UART_DATA_W-1:1]};
                        bit_q   <= bit_q + 1'b1;
`ifdef UART_RX_MONITOR_PARITY_EN
                        if (bit_q == 3'd7) state_q <= PARITY;
`else
                        if (bit_q == 3'd7) state_q <= STOP;
`endif
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
`ifdef UART_RX_MONITOR_PARITY_EN
                PARITY: begin
                    if (tick_full) begin
                        tick_q  <= '0;
                        state_q <= STOP;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_full) begin
                        tick_q <= '0;
                        if (rx_s_q) begin
                            push_q  <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= BREAK;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a set event in the same cycle as clr_err wins.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= frame_set | (frame_err_q & ~clr_err);
            overflow_q  <= ovf_set | (overflow_q & ~clr_err);
        end
    end

`ifdef UART_RX_MONITOR_PARITY_EN
    logic parity_set;
    logic parity_err_q;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign parity_set = (state_q == PARITY) && tick_full && (^{shift_q, rx_s_q});

    // Sticky parity flag, independent of whether the byte is pushed.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) parity_err_q <= 1'b0;
        else          parity_err_q <= parity_set | (parity_err_q & ~clr_err);
    end

    assign parity_err = parity_err_q;
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk         (HCLK),
        .rst_n       (HRESETn),
        .push_i      (push_q),
        .push_data_i (shift_q),
        .pop_i       (stream.m_ready),
        .head_o      (stream.m_data),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .level_o     (level)
    );

    assign stream.m_valid = ~fifo_empty;
    assign busy           = busy_q;
    assign frame_err      = frame_err_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor: directed scenarios plus
// randomized frames scored against a byte-queue model of the receiver.
module tb_uart_rx_monitor;

    localparam int C = 16;
    localparam int D = 16;
`ifdef UART_RX_MONITOR_PARITY_EN
    localparam int LAT = 3 + C/2 + 10*C + 1;
`else
    localparam int LAT = 3 + C/2 + 9*C + 1;
`endif

    logic                 HCLK = 1'b0;
    logic                 HRESETn = 1'b0;
    logic                 rx = 1'b1;
    logic                 clr_err = 1'b0;
    logic [$clog2(D):0]   level;
    logic                 busy;
    logic                 frame_err;
    logic                 overflow;
`ifdef UART_RX_MONITOR_PARITY_EN
    logic                 parity_err;
`endif

    uart_rx_monitor_if sif();

    uart_rx_monitor #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .rx_i      (rx),
        .stream    (sif),
        .level     (level),
        .busy      (busy),
        .frame_err (frame_err),
        .overflow  (overflow),
`ifdef UART_RX_MONITOR_PARITY_EN
        .parity_err(parity_err),
`endif
        .clr_err   (clr_err)
    );

    always #5 HCLK = ~HCLK;

    int         cyc = 0;
    int         fall_cyc = 0;
    int         rise_cyc = -1;
    logic       mv_prev = 1'b0;
    int         vecs = 0;
    int         errs = 0;
    logic [7:0] expq[$];
    logic       exp_ferr = 1'b0;
    logic       exp_ovf = 1'b0;

    always @(posedge HCLK) cyc <= cyc + 1;

    // Record the cycle on which m_valid last rose.
    always @(negedge HCLK) begin
        if (sif.m_valid && !mv_prev) rise_cyc <= cyc;
        mv_prev <= sif.m_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        fall_cyc = cyc;
        hold(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(C);
        end
`ifdef UART_RX_MONITOR_PARITY_EN
        rx = ^b;
        hold(C);
`endif
        rx = stop_ok;
        hold(C);
        rx = 1'b1;
    endtask

    // Model: a good frame is queued unless the FIFO is full; a bad stop flags a framing error.
    task automatic send_model(input logic [7:0] b, input logic stop_ok);
        send_frame(b, stop_ok);
        if (!stop_ok)           exp_ferr = 1'b1;
        else if (expq.size() < D) expq.push_back(b);
        else                    exp_ovf = 1'b1;
    endtask

    task automatic pop_exp();
        logic [7:0] e;
        e = expq.pop_front();
        chk("pop_valid", sif.m_valid, 1'b1);
        chk("pop_data", sif.m_data, e);
        sif.m_ready = 1'b1;
        hold(1);
        sif.m_ready = 1'b0;
    endtask

    task automatic drain();
        while (expq.size() > 0) pop_exp();
        chk("drained_valid", sif.m_valid, 1'b0);
        chk("drained_level", level, 0);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        hold(1);
        clr_err = 1'b0;
        exp_ferr = 1'b0;
        exp_ovf = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic       ok;
        int         gap;
        logic [7:0] burst[4];

        sif.m_ready = 1'b0;
        hold(3);
        chk("rst_valid", sif.m_valid, 1'b0);
        chk("rst_data", sif.m_data, 8'h00);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        HRESETn = 1'b1;
        hold(3);

        // Single frame and its latency from the start edge.
        send_model(8'h41, 1'b1);
        chk("latency", rise_cyc - fall_cyc, LAT);
        chk("single_level", level, 1);
        pop_exp();
        chk("single_empty", level, 0);

        // Back-to-back burst: fixed patterns then random bytes.
        burst = '{8'h00, 8'hFF, 8'h55, 8'hA5};
        for (int i = 0; i < 4; i++) send_model(burst[i], 1'b1);
        for (int i = 0; i < 8; i++) send_model(8'($urandom), 1'b1);
        chk("burst_level", level, expq.size());
        chk("burst_ferr", frame_err, 1'b0);
        drain();

        // False start: 4-cycle glitch.
        rx = 1'b0;
        hold(2);
        chk("fs_busy_early", busy, 1'b0);
        hold(1);
        chk("fs_busy_rise", busy, 1'b1);
        hold(1);
        rx = 1'b1;
        hold(C);
        chk("fs_busy_fall", busy, 1'b0);
        chk("fs_level", level, 0);

        // Break: long low line yields one framing error and no push.
        rx = 1'b0;
        hold(40 * C);
        rx = 1'b1;
        hold(4);
        chk("brk_ferr", frame_err, 1'b1);
        chk("brk_level", level, 0);
        chk("brk_busy", busy, 1'b0);
        send_model(8'h3C, 1'b1);
        chk("brk_after_level", level, 1);
        pop_exp();
        pulse_clr();
        chk("brk_clr", frame_err, 1'b0);

        // Overflow: 17 bytes into a 16-deep FIFO with no pops.
        for (int i = 1; i <= 17; i++) send_model(8'(i), 1'b1);
        chk("ovf_level", level, D);
        chk("ovf_flag", overflow, exp_ovf);
        drain();
        pulse_clr();
        chk("ovf_clr", overflow, 1'b0);

        // Full FIFO with a pop on the same edge as the 17th push.
        for (int i = 1; i <= 16; i++) send_model(8'(i), 1'b1);
        fork
            send_frame(8'h11, 1'b1);
            begin
                hold(LAT - 1);
                sif.m_ready = 1'b1;
                hold(1);
                sif.m_ready = 1'b0;
            end
        join
        void'(expq.pop_front());
        expq.push_back(8'h11);
        chk("pp_ovf", overflow, 1'b0);
        chk("pp_level", level, D);
        drain();

        // Reset during data bit 4, with one byte already queued.
        send_model(8'hC3, 1'b1);
        b = 8'h99;
        rx = 1'b0;
        hold(C);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            hold(C);
        end
        rx = b[4];
        hold(C / 2);
        HRESETn = 1'b0;
        rx = 1'b1;
        hold(2);
        expq.delete();
        chk("mr_valid", sif.m_valid, 1'b0);
        chk("mr_data", sif.m_data, 8'h00);
        chk("mr_level", level, 0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_ferr", frame_err, 1'b0);
        chk("mr_ovf", overflow, 1'b0);
        HRESETn = 1'b1;
        hold(4);
        send_model(8'h7E, 1'b1);
        chk("mr_after_level", level, 1);
        pop_exp();

        // Randomized frames, some with a bad stop bit, random idle gaps.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) begin
                ok = ($urandom_range(0, 3) != 0);
                send_model(8'($urandom), ok);
                gap = ok ? $urandom_range(0, C) : $urandom_range(1, C);
                if (gap > 0) hold(gap);
            end
            hold(4);
            chk("rnd_level", level, expq.size());
            chk("rnd_ferr", frame_err, exp_ferr);
            chk("rnd_ovf", overflow, exp_ovf);
            chk("rnd_busy", busy, 1'b0);
            drain();
            pulse_clr();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
